audio_sample_scheduler: RTL

- Sequences one audio sample period on the 20 MHz sclk domain.
- Generates the ADC sample strobe, then waits for the selected path's result: raw ADC, lowpass, bandpass or highpass.
- Forwards exactly one word per period to the DAC sink, with timeout substitution and overrun detection.
- Replaces the free-running sample divider plus combinational source switcher; the channel select changes only on sample boundaries.

---
 rtl/audio_sample_scheduler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/audio_sample_scheduler.sv
// Sample-period sequencer for the audio path. It strobes the ADC, waits for the
// selected channel's result (or times out), and forwards one word per period to the DAC.
module audio_sample_scheduler #(
    parameter int DATA_W     = 12,
    parameter int SAMPLE_DIV = 450,
    parameter int TIMEOUT    = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        select,
    output logic              sample,
    input  logic [DATA_W-1:0] sink_data_0,
    input  logic [DATA_W-1:0] sink_data_1,
    input  logic [DATA_W-1:0] sink_data_2,
    input  logic [DATA_W-1:0] sink_data_3,
    input  logic              sink_valid_0,
    input  logic              sink_valid_1,
    input  logic              sink_valid_2,
    input  logic              sink_valid_3,
    input  logic [1:0]        sink_error_0,
    input  logic [1:0]        sink_error_1,
    input  logic [1:0]        sink_error_2,
    input  logic [1:0]        sink_error_3,
    output logic [DATA_W-1:0] source_data,
    output logic              source_valid,
    output logic [1:0]        source_error,
    output logic [1:0]        active_sel,
    output logic              overrun,
    output logic [7:0]        timeout_count
);

    localparam int CW = 16;
    localparam logic [CW-1:0] DIV_LAST = CW'(SAMPLE_DIV - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [1:0]    ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     div_q;
    logic [CW-1:0]     div_d;
    logic [CW-1:0]     timer_q;
    logic              sample_q;
    logic [DATA_W-1:0] held_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;
    logic [1:0]        err_q;
    logic [1:0]        asel_q;
    logic              ovr_q;
    logic [7:0]        tcnt_q;

    logic              sel_valid;
    logic [DATA_W-1:0] sel_data;
    logic [1:0]        sel_err;

    // Free-running divider; the strobe register is set one cycle ahead so it
    // lines up with divider == SAMPLE_DIV-1.
    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + CW'(1);
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        sel_err   = 2'b00;
        case (asel_q)
            2'd0: begin sel_valid = sink_valid_0; sel_data = sink_data_0; sel_err = sink_error_0; end
            2'd1: begin sel_valid = sink_valid_1; sel_data = sink_data_1; sel_err = sink_error_1; end
            2'd2: begin sel_valid = sink_valid_2; sel_data = sink_data_2; sel_err = sink_error_2; end
            default: begin sel_valid = sink_valid_3; sel_data = sink_data_3; sel_err = sink_error_3; end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            div_q    <= '0;
            timer_q  <= '0;
            sample_q <= 1'b0;
            held_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 2'b00;
            asel_q   <= 2'd0;
            ovr_q    <= 1'b0;
            tcnt_q   <= 8'd0;
        end else begin
            div_q    <= div_d;
            sample_q <= (div_d == DIV_LAST);
            valid_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sample_q) begin
                        asel_q  <= select;
                        timer_q <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (sample_q) begin
                        ovr_q <= 1'b1;
                    end
                    // A valid in the final timer cycle still counts as a capture.
                    if (sel_valid) begin
                        data_q  <= sel_data;
                        err_q   <= sel_err;
                        held_q  <= sel_data;
                        valid_q <= 1'b1;
                        state_q <= EMIT;
                    end else if (timer_q == TO_LAST) begin
                        data_q  <= held_q;
                        err_q   <= ERR_TIMEOUT;
                        valid_q <= 1'b1;
                        if (tcnt_q != 8'hFF) begin
                            tcnt_q <= tcnt_q + 8'd1;
                        end
                        state_q <= EMIT;
                    end else begin
                        timer_q <= timer_q + CW'(1);
                    end
                end
                EMIT: begin
                    if (sample_q) begin
                        ovr_q <= 1'b1;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sample        = sample_q;
    assign source_data   = data_q;
    assign source_valid  = valid_q;
    assign source_error  = err_q;
    assign active_sel    = asel_q;
    assign overrun       = ovr_q;
    assign timeout_count = tcnt_q;

endmodule
